// File: rtl/frac_clk_div_if.sv
// Divided-clock output bundle for frac_clk_div.
// Latency: none, the bundle is just wires.
// Backpressure: none, the divider output is free-running.
// Ports: clk_out - divided clock, driven by the master (the divider) and
//        observed by the slave (the consumer of the low-rate clock/strobe).
interface frac_clk_div_if;
   logic clk_out;

   modport master (output clk_out);
   modport slave  (input  clk_out);
endinterface

// File: rtl/frac_clk_div.sv
// Fractional clock divider, dual-modulus N / N+1 with accumulator control.
// Latency: clk_out rises on the first clk_in edge with rst low, no dead cycles.
// Backpressure: none, the output is free-running once reset is released.
// Ports: clk_in - single clock, all logic on its rising edge
//        rst    - synchronous active-high reset (holds clk_out low)
//        div_if - master side of frac_clk_div_if, carries registered clk_out
module frac_clk_div #(
   parameter int DIV_INT = 8,   // integer part of ratio, >= 2
   parameter int DIV_NUM = 1,   // fractional numerator, 0 <= DIV_NUM < DIV_DEN
   parameter int DIV_DEN = 10   // fractional denominator, >= 1
) (
   input  logic           clk_in,
   input  logic           rst,
   frac_clk_div_if.master div_if
);

   // Counter must hold DIV_INT+1; accumulator sum must hold 2*DIV_DEN-1.
   localparam int CW = $clog2(DIV_INT + 2);
   localparam int AW = $clog2(2 * DIV_DEN);

   localparam logic [CW-1:0] LEN_S = CW'(DIV_INT);
   localparam logic [CW-1:0] LEN_L = CW'(DIV_INT + 1);
   localparam logic [AW-1:0] NUM   = AW'(DIV_NUM);
   localparam logic [AW-1:0] DEN   = AW'(DIV_DEN);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] plen_q, plen_d;
   logic [AW-1:0] acc_q, acc_d;
   logic          clk_out_q, clk_out_d;
   logic          pend_q, pend_d;

   logic [AW-1:0] sum;
   logic          period_start;

   always_comb begin
      sum          = acc_q + NUM;
      // After reset the first live edge always opens a period; otherwise a
      // period opens on the edge following the last offset of the current one.
      period_start = pend_q || (cnt_q == plen_q - CW'(1));

      cnt_d  = cnt_q + CW'(1);
      plen_d = plen_q;
      acc_d  = acc_q;
      pend_d = 1'b0;

      if (period_start) begin
         cnt_d = '0;
         if (sum >= DEN) begin
            plen_d = LEN_L;
            acc_d  = sum - DEN;
         end else begin
            plen_d = LEN_S;
            acc_d  = sum;
         end
      end

      // High for the first floor(plen/2) offsets, so an odd-length period
      // puts its extra cycle in the low phase.
      clk_out_d = (cnt_d < (plen_d >> 1));
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q     <= '0;
         plen_q    <= LEN_S;
         acc_q     <= '0;
         clk_out_q <= 1'b0;
         pend_q    <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         plen_q    <= plen_d;
         acc_q     <= acc_d;
         clk_out_q <= clk_out_d;
         pend_q    <= pend_d;
      end
   end

   assign div_if.clk_out = clk_out_q;

endmodule

// File: tb/tb_frac_clk_div.sv
// Bench for frac_clk_div: three instances (8.1 default, 5.0, 3.5) share
// clock and reset; a per-edge expectation queue and a per-period length
// queue are filled from an independent floor-based ratio model.
`timescale 1ns/1ps
module tb_frac_clk_div;
   localparam int ND = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   frac_clk_div_if if0();
   frac_clk_div_if if1();
   frac_clk_div_if if2();

   frac_clk_div #(.DIV_INT(8), .DIV_NUM(1), .DIV_DEN(10)) u_div0 (
      .clk_in(clk), .rst(rst), .div_if(if0));
   frac_clk_div #(.DIV_INT(5), .DIV_NUM(0), .DIV_DEN(1))  u_div1 (
      .clk_in(clk), .rst(rst), .div_if(if1));
   frac_clk_div #(.DIV_INT(3), .DIV_NUM(1), .DIV_DEN(2))  u_div2 (
      .clk_in(clk), .rst(rst), .div_if(if2));

   always #20000 clk = ~clk;   // 40 us period

   logic [ND-1:0] obs;
   assign obs = {if2.clk_out, if1.clk_out, if0.clk_out};

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic int p_int(input int d);
      case (d) 0: return 8; 1: return 5; default: return 3; endcase
   endfunction
   function automatic int p_num(input int d);
      case (d) 0: return 1; 1: return 0; default: return 1; endcase
   endfunction
   function automatic int p_den(input int d);
      case (d) 0: return 10; 1: return 1; default: return 2; endcase
   endfunction

   // Length of 1-based period k: the fractional part carries whenever
   // floor(k*NUM/DEN) steps up.
   function automatic int plen_of(input int d, input int k);
      return p_int(d) + (k * p_num(d)) / p_den(d) - ((k - 1) * p_num(d)) / p_den(d);
   endfunction

   // Model state
   int  m_k[ND], m_j[ND], m_len[ND];
   bit  m_pend[ND];

   // Scoreboards
   logic [ND-1:0] exp_q[$];
   int plq0[$], plq1[$], plq2[$];

   // Observation state
   int cyc = 0;
   int rise_cnt[ND];
   int last_rise[ND];
   logic [ND-1:0] prev = '0;

   task automatic pl_push(input int d, input int len);
      case (d)
         0: plq0.push_back(len);
         1: plq1.push_back(len);
         default: plq2.push_back(len);
      endcase
   endtask

   task automatic pl_clear(input int d);
      case (d)
         0: plq0.delete();
         1: plq1.delete();
         default: plq2.delete();
      endcase
   endtask

   task automatic pl_check(input int d, input int interval);
      int sz;
      int e;
      case (d)
         0: sz = plq0.size();
         1: sz = plq1.size();
         default: sz = plq2.size();
      endcase
      if (sz == 0) begin
         chk_eq($sformatf("plen_q_empty%0d", d), 0, 1);
      end else begin
         case (d)
            0: e = plq0.pop_front();
            1: e = plq1.pop_front();
            default: e = plq2.pop_front();
         endcase
         chk_eq($sformatf("plen%0d", d), interval, e);
      end
   endtask

   // Drive one edge: set rst, push the model's expectation, clock, then
   // pop and compare away from the edge.
   task automatic step(input logic r);
      logic [ND-1:0] e;
      rst = r;
      for (int d = 0; d < ND; d++) begin
         if (r) begin
            m_pend[d] = 1'b1;
            m_k[d]    = 0;
            m_j[d]    = 0;
            e[d]      = 1'b0;
            pl_clear(d);
         end else begin
            if (m_pend[d] || m_j[d] == m_len[d] - 1) begin
               m_k[d]    = m_k[d] + 1;
               m_len[d]  = plen_of(d, m_k[d]);
               m_j[d]    = 0;
               m_pend[d] = 1'b0;
               pl_push(d, m_len[d]);
            end else begin
               m_j[d] = m_j[d] + 1;
            end
            e[d] = (m_j[d] < m_len[d] / 2);
         end
      end
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      for (int d = 0; d < ND; d++) begin
         chk_eq($sformatf("clk_out%0d", d), int'(obs[d]), int'(e[d]));
         if (r) begin
            last_rise[d] = -1;
         end else if (obs[d] && !prev[d]) begin
            rise_cnt[d]++;
            if (last_rise[d] >= 0) pl_check(d, cyc - last_rise[d]);
            last_rise[d] = cyc;
         end
      end
      prev = obs;
   endtask

   task automatic clear_rises();
      for (int d = 0; d < ND; d++) rise_cnt[d] = 0;
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         m_k[d] = 0; m_j[d] = 0; m_len[d] = p_int(d); m_pend[d] = 1'b1;
         rise_cnt[d] = 0; last_rise[d] = -1;
      end

      // Reset held for several edges: outputs stay low.
      repeat (3) step(1'b1);
      chk_eq("rst_low0", int'(obs[0]), 0);

      // First edge after release drives clk_out high.
      clear_rises();
      step(1'b0);
      chk_eq("first_hi0", int'(obs[0]), 1);
      chk_eq("first_hi2", int'(obs[2]), 1);

      // Integer divide by 5: 20 rising edges in 100 cycles.
      repeat (99) step(1'b0);
      chk_eq("rise100_div5", rise_cnt[1], 20);

      // Long run of 810 cycles.
      repeat (710) step(1'b0);
      chk_eq("rise810_div8p1", rise_cnt[0], 100);
      chk_eq("rise810_div5",   rise_cnt[1], 162);
      chk_eq("rise810_div3p5", rise_cnt[2], 232);

      // Fresh reset, then reset for one edge in the high phase of period 3
      // of the default instance (period 3 starts at offset 16).
      repeat (2) step(1'b1);
      repeat (18) step(1'b0);
      chk_eq("p3_high0", int'(obs[0]), 1);
      step(1'b1);
      chk_eq("mid_rst0", int'(obs[0]), 0);

      // Sequence restarts: 10 periods in 81 cycles, 9-cycle period at slot 10.
      clear_rises();
      repeat (81) step(1'b0);
      chk_eq("restart81_div8p1", rise_cnt[0], 10);
      repeat (30) step(1'b0);
      chk_eq("restart_rise_div8p1", rise_cnt[0], 14);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Safety net: the bench is bounded by its step loop, this guards a stall.
   initial begin
      #100ms;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end
endmodule
